// File: rtl/ca_pkg.sv
// ca_pkg: shared state, opcode and datapath select encodings for the multi-cycle RV32I controller
package ca_pkg;

    typedef enum logic [3:0] {
        FETCH,
        DECODE,
        MEMADR,
        MEMREAD,
        MEMWB,
        MEMWRITE,
        EXEC_R,
        EXEC_I,
        ALUWB,
        BRANCH,
        JAL,
        JALR,
        LINK,
        LUI,
        HALT
    } state_t;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;

    localparam logic [2:0] ALU_ADD  = 3'b000;
    localparam logic [2:0] ALU_SUB  = 3'b001;
    localparam logic [2:0] ALU_AND  = 3'b010;
    localparam logic [2:0] ALU_OR   = 3'b011;
    localparam logic [2:0] ALU_XOR  = 3'b100;
    localparam logic [2:0] ALU_SLT  = 3'b101;
    localparam logic [2:0] ALU_SLTU = 3'b110;

    localparam logic [2:0] IMM_I = 3'b000;
    localparam logic [2:0] IMM_S = 3'b001;
    localparam logic [2:0] IMM_B = 3'b010;
    localparam logic [2:0] IMM_J = 3'b011;
    localparam logic [2:0] IMM_U = 3'b100;

    localparam logic [1:0] RES_ALUOUT    = 2'b00;
    localparam logic [1:0] RES_DATA      = 2'b01;
    localparam logic [1:0] RES_ALURESULT = 2'b10;
    localparam logic [1:0] RES_IMMEXT    = 2'b11;

    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_A     = 2'b10;

    localparam logic [1:0] SRCB_B    = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

    localparam logic [1:0] ALUOP_ADD    = 2'b00;
    localparam logic [1:0] ALUOP_BRANCH = 2'b01;
    localparam logic [1:0] ALUOP_FUNC   = 2'b10;

    function automatic logic known_opcode(input logic [6:0] op);
        return op == OP_LOAD || op == OP_STORE || op == OP_RTYPE || op == OP_ITYPE ||
               op == OP_BRANCH || op == OP_JAL || op == OP_JALR || op == OP_LUI;
    endfunction

endpackage

// File: rtl/alu_decoder.sv
// alu_decoder: maps alu_op/func fields to an ALU operation and flags unsupported func3 codes
module alu_decoder
    import ca_pkg::*;
(
    input  logic [1:0] alu_op,
    input  logic [2:0] func3,
    input  logic       func7_5,
    input  logic       op_5,
    output logic [2:0] alu_control,
    output logic       illegal
);

    // branches compare with sub/slt; R/I ops decode func3, with sub only for R-type (op_5)
    always_comb begin
        alu_control = ALU_ADD;
        illegal = 1'b0;
        if (alu_op == ALUOP_BRANCH) begin
            case (func3)
                3'b000, 3'b001: alu_control = ALU_SUB;
                3'b100, 3'b101: alu_control = ALU_SLT;
                default: illegal = 1'b1;
            endcase
        end else if (alu_op == ALUOP_FUNC) begin
            case (func3)
                3'b000: alu_control = (op_5 && func7_5) ? ALU_SUB : ALU_ADD;
                3'b010: alu_control = ALU_SLT;
                3'b011: alu_control = ALU_SLTU;
                3'b100: alu_control = ALU_XOR;
                3'b110: alu_control = ALU_OR;
                3'b111: alu_control = ALU_AND;
                default: illegal = 1'b1;
            endcase
        end
    end

endmodule

// File: rtl/multicycle_controller.sv
// multicycle_controller: main sequencing FSM for the multi-cycle RV32I datapath
module multicycle_controller
    import ca_pkg::*;
#(
    parameter bit ILLEGAL_HALT = 1'b0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [6:0] opcode,
    input  logic [2:0] func3,
    input  logic [6:0] func7,
    input  logic       zero,
    output logic       PCWrite,
    output logic       AdrSrc,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic       RegWrite,
    output logic [1:0] ResultSrc,
    output logic [1:0] ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [2:0] ALUControl,
    output logic [2:0] ImmSrc,
    output logic       instr_done,
    output logic       illegal_instr
);

    state_t state;
    logic [1:0] alu_op;
    logic [2:0] dec_alu;
    logic dec_ill;
    logic is_r;
    logic is_i;
    logic is_b;
    logic bad;
    logic taken;
    logic unused_func7;

    assign unused_func7 = ^{func7[6], func7[4:0]};
    assign is_r = opcode == OP_RTYPE;
    assign is_i = opcode == OP_ITYPE;
    assign is_b = opcode == OP_BRANCH;

    // DECODE borrows the decoder to validate func3 before committing to an execute state
    assign alu_op = (state == BRANCH || (state == DECODE && is_b)) ? ALUOP_BRANCH :
                    (state == EXEC_R || state == EXEC_I || (state == DECODE && (is_r || is_i))) ? ALUOP_FUNC :
                    ALUOP_ADD;
    assign bad = !known_opcode(opcode) || dec_ill;
    assign taken = (func3 == 3'b000 && zero) || (func3 == 3'b001 && !zero) ||
                   (func3 == 3'b100 && !zero) || (func3 == 3'b101 && zero);

    alu_decoder u_alu_decoder (
        .alu_op(alu_op),
        .func3(func3),
        .func7_5(func7[5]),
        .op_5(opcode[5]),
        .alu_control(dec_alu),
        .illegal(dec_ill)
    );

    // state sequencing; reset always lands in FETCH
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= FETCH;
        end else begin
            case (state)
                FETCH: state <= DECODE;
                DECODE: begin
                    if (bad) begin
                        state <= ILLEGAL_HALT ? HALT : FETCH;
                    end else begin
                        case (opcode)
                            OP_LOAD, OP_STORE: state <= MEMADR;
                            OP_RTYPE: state <= EXEC_R;
                            OP_ITYPE: state <= EXEC_I;
                            OP_BRANCH: state <= BRANCH;
                            OP_JAL: state <= JAL;
                            OP_JALR: state <= JALR;
                            OP_LUI: state <= LUI;
                            default: state <= FETCH;
                        endcase
                    end
                end
                MEMADR: state <= (opcode == OP_LOAD) ? MEMREAD : MEMWRITE;
                MEMREAD: state <= MEMWB;
                EXEC_R, EXEC_I, JAL, LINK: state <= ALUWB;
                JALR: state <= LINK;
                HALT: state <= HALT;
                default: state <= FETCH;
            endcase
        end
    end

    // per-state datapath controls, forced quiet while reset is held
    always_comb begin
        PCWrite = 1'b0;
        AdrSrc = 1'b0;
        MemWrite = 1'b0;
        IRWrite = 1'b0;
        RegWrite = 1'b0;
        ResultSrc = RES_ALUOUT;
        ALUSrcA = SRCA_PC;
        ALUSrcB = SRCB_B;
        ALUControl = ALU_ADD;
        ImmSrc = IMM_I;
        instr_done = 1'b0;
        illegal_instr = 1'b0;
        if (rst) begin
            case (state)
                FETCH: begin
                    IRWrite = 1'b1;
                    PCWrite = 1'b1;
                    ALUSrcB = SRCB_FOUR;
                    ResultSrc = RES_ALURESULT;
                end
                DECODE: begin
                    ALUSrcA = SRCA_OLDPC;
                    ALUSrcB = SRCB_IMM;
                    ImmSrc = (opcode == OP_JAL) ? IMM_J : IMM_B;
                    illegal_instr = bad;
                end
                MEMADR: begin
                    ALUSrcA = SRCA_A;
                    ALUSrcB = SRCB_IMM;
                    ImmSrc = (opcode == OP_STORE) ? IMM_S : IMM_I;
                end
                MEMREAD: AdrSrc = 1'b1;
                MEMWB: begin
                    ResultSrc = RES_DATA;
                    RegWrite = 1'b1;
                    instr_done = 1'b1;
                end
                MEMWRITE: begin
                    AdrSrc = 1'b1;
                    MemWrite = 1'b1;
                    instr_done = 1'b1;
                end
                EXEC_R: begin
                    ALUSrcA = SRCA_A;
                    ALUControl = dec_alu;
                end
                EXEC_I: begin
                    ALUSrcA = SRCA_A;
                    ALUSrcB = SRCB_IMM;
                    ALUControl = dec_alu;
                end
                ALUWB: begin
                    RegWrite = 1'b1;
                    instr_done = 1'b1;
                end
                BRANCH: begin
                    ALUSrcA = SRCA_A;
                    ALUControl = dec_alu;
                    PCWrite = taken;
                    instr_done = 1'b1;
                end
                JAL: begin
                    ALUSrcA = SRCA_OLDPC;
                    ALUSrcB = SRCB_FOUR;
                    PCWrite = 1'b1;
                end
                JALR: begin
                    ALUSrcA = SRCA_A;
                    ALUSrcB = SRCB_IMM;
                    ResultSrc = RES_ALURESULT;
                    PCWrite = 1'b1;
                end
                LINK: begin
                    ALUSrcA = SRCA_OLDPC;
                    ALUSrcB = SRCB_FOUR;
                end
                LUI: begin
                    ImmSrc = IMM_U;
                    ResultSrc = RES_IMMEXT;
                    RegWrite = 1'b1;
                    instr_done = 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_multicycle_controller.sv
// tb_multicycle_controller: per-instruction cycle tables checked against two controller instances
module tb_multicycle_controller;

    logic clk = 1'b0;
    logic rst;
    logic [6:0] opcode;
    logic [2:0] func3;
    logic [6:0] func7;
    logic zero;

    logic pcw0, adr0, mw0, irw0, rw0, done0, ill0;
    logic [1:0] rs0, sa0, sb0;
    logic [2:0] alu0, imm0;
    logic pcw1, adr1, mw1, irw1, rw1, done1, ill1;
    logic [1:0] rs1, sa1, sb1;
    logic [2:0] alu1, imm1;
    logic [18:0] o0, o1;

    int n_tests = 0;
    int n_fail = 0;
    logic [18:0] exq[$];

    localparam logic [6:0] LW = 7'b0000011, SW = 7'b0100011, RT = 7'b0110011, IT = 7'b0010011;
    localparam logic [6:0] BR = 7'b1100011, JL = 7'b1101111, JR = 7'b1100111, LU = 7'b0110111;

    multicycle_controller #(.ILLEGAL_HALT(1'b0)) dut0 (
        .clk(clk), .rst(rst), .opcode(opcode), .func3(func3), .func7(func7), .zero(zero),
        .PCWrite(pcw0), .AdrSrc(adr0), .MemWrite(mw0), .IRWrite(irw0), .RegWrite(rw0),
        .ResultSrc(rs0), .ALUSrcA(sa0), .ALUSrcB(sb0), .ALUControl(alu0), .ImmSrc(imm0),
        .instr_done(done0), .illegal_instr(ill0)
    );

    multicycle_controller #(.ILLEGAL_HALT(1'b1)) dut1 (
        .clk(clk), .rst(rst), .opcode(opcode), .func3(func3), .func7(func7), .zero(zero),
        .PCWrite(pcw1), .AdrSrc(adr1), .MemWrite(mw1), .IRWrite(irw1), .RegWrite(rw1),
        .ResultSrc(rs1), .ALUSrcA(sa1), .ALUSrcB(sb1), .ALUControl(alu1), .ImmSrc(imm1),
        .instr_done(done1), .illegal_instr(ill1)
    );

    assign o0 = {pcw0, adr0, mw0, irw0, rw0, rs0, sa0, sb0, alu0, imm0, done0, ill0};
    assign o1 = {pcw1, adr1, mw1, irw1, rw1, rs1, sa1, sb1, alu1, imm1, done1, ill1};

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [18:0] v(input logic pcw, input logic adr, input logic mw, input logic irw,
                                      input logic rw, input logic [1:0] rs, input logic [1:0] sa,
                                      input logic [1:0] sb, input logic [2:0] alu, input logic [2:0] imm,
                                      input logic done, input logic ill);
        return {pcw, adr, mw, irw, rw, rs, sa, sb, alu, imm, done, ill};
    endfunction

    function automatic logic [18:0] fetch_v();
        return v(1, 0, 0, 1, 0, 2'b10, 2'b00, 2'b10, 3'b000, 3'b000, 0, 0);
    endfunction

    // {illegal, ALU op} by instruction mnemonic: beq/bne sub, blt/bge slt; add/sub slt sltu xor or and
    function automatic logic [3:0] alu_of(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7);
        if (op == BR) begin
            if (f3 == 3'd0 || f3 == 3'd1) return 4'b0001;
            if (f3 == 3'd4 || f3 == 3'd5) return 4'b0101;
            return 4'b1000;
        end
        case (f3)
            3'd0: return (op == RT && f7[5]) ? 4'b0001 : 4'b0000;
            3'd2: return 4'b0101;
            3'd3: return 4'b0110;
            3'd4: return 4'b0100;
            3'd6: return 4'b0011;
            3'd7: return 4'b0010;
            default: return 4'b1000;
        endcase
    endfunction

    // expected per-cycle outputs for one instruction when illegal opcodes fall back to FETCH
    task automatic build(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7, input logic z);
        logic [3:0] a;
        logic ill;
        logic tk;
        logic [18:0] wb;
        a = alu_of(op, f3, f7);
        ill = !(op inside {LW, SW, RT, IT, BR, JL, JR, LU}) || ((op == RT || op == IT || op == BR) && a[3]);
        tk = (f3 == 3'd0) ? z : (f3 == 3'd1) ? !z : (f3 == 3'd4) ? !z : z;
        wb = v(0, 0, 0, 0, 1, 2'b00, 2'b00, 2'b00, 3'b000, 3'b000, 1, 0);
        exq.delete();
        exq.push_back(fetch_v());
        exq.push_back(v(0, 0, 0, 0, 0, 2'b00, 2'b01, 2'b01, 3'b000, (op == JL) ? 3'b011 : 3'b010, 0, ill));
        if (!ill) begin
            case (op)
                LW: begin
                    exq.push_back(v(0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 3'b000, 3'b000, 0, 0));
                    exq.push_back(v(0, 1, 0, 0, 0, 2'b00, 2'b00, 2'b00, 3'b000, 3'b000, 0, 0));
                    exq.push_back(v(0, 0, 0, 0, 1, 2'b01, 2'b00, 2'b00, 3'b000, 3'b000, 1, 0));
                end
                SW: begin
                    exq.push_back(v(0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 3'b000, 3'b001, 0, 0));
                    exq.push_back(v(0, 1, 1, 0, 0, 2'b00, 2'b00, 2'b00, 3'b000, 3'b000, 1, 0));
                end
                RT: begin
                    exq.push_back(v(0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b00, a[2:0], 3'b000, 0, 0));
                    exq.push_back(wb);
                end
                IT: begin
                    exq.push_back(v(0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, a[2:0], 3'b000, 0, 0));
                    exq.push_back(wb);
                end
                BR: exq.push_back(v(tk, 0, 0, 0, 0, 2'b00, 2'b10, 2'b00, a[2:0], 3'b000, 1, 0));
                JL: begin
                    exq.push_back(v(1, 0, 0, 0, 0, 2'b00, 2'b01, 2'b10, 3'b000, 3'b000, 0, 0));
                    exq.push_back(wb);
                end
                JR: begin
                    exq.push_back(v(1, 0, 0, 0, 0, 2'b10, 2'b10, 2'b01, 3'b000, 3'b000, 0, 0));
                    exq.push_back(v(0, 0, 0, 0, 0, 2'b00, 2'b01, 2'b10, 3'b000, 3'b000, 0, 0));
                    exq.push_back(wb);
                end
                default: exq.push_back(v(0, 0, 0, 0, 1, 2'b11, 2'b00, 2'b00, 3'b000, 3'b100, 1, 0));
            endcase
        end
    endtask

    // entered in the low clock phase with both DUTs in FETCH; leaves them at the next FETCH
    task automatic run(input string name, input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7,
                       input logic z, input bit both);
        opcode = op;
        func3 = f3;
        func7 = f7;
        zero = z;
        build(op, f3, f7, z);
        foreach (exq[i]) begin
            #1;
            n_tests++;
            if (o0 !== exq[i]) begin
                n_fail++;
                $display("FAIL %s dut0 cycle %0d: got %b expected %b", name, i + 1, o0, exq[i]);
            end
            if (both) begin
                n_tests++;
                if (o1 !== exq[i]) begin
                    n_fail++;
                    $display("FAIL %s dut1 cycle %0d: got %b expected %b", name, i + 1, o1, exq[i]);
                end
            end
            n_tests++;
            if ((o0[16] & o0[14]) !== 1'b0 || (o0[18] & o0[15]) !== (i == 0)) begin
                n_fail++;
                $display("FAIL %s invariant cycle %0d: got %b", name, i + 1, o0);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        opcode = LW;
        func3 = 3'd2;
        func7 = 7'd0;
        zero = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        n_tests++;
        if (o0 !== 19'd0 || o1 !== 19'd0) begin
            n_fail++;
            $display("FAIL reset_hold: got %b / %b expected all zero", o0, o1);
        end
        @(negedge clk);
        rst = 1'b1;
        #1;
        n_tests++;
        if (o0 !== fetch_v() || o1 !== fetch_v()) begin
            n_fail++;
            $display("FAIL reset_release: got %b / %b expected %b", o0, o1, fetch_v());
        end
        repeat (3) @(negedge clk);
        #1;
        n_tests++;
        if (o0 !== v(0, 1, 0, 0, 0, 2'b00, 2'b00, 2'b00, 3'b000, 3'b000, 0, 0)) begin
            n_fail++;
            $display("FAIL reach_memread: got %b", o0);
        end
        rst = 1'b0;
        #1;
        n_tests++;
        if (o0 !== 19'd0 || o1 !== 19'd0) begin
            n_fail++;
            $display("FAIL async_reset_midinstr: got %b / %b expected all zero", o0, o1);
        end
        @(negedge clk);
        #1;
        n_tests++;
        if (o0 !== 19'd0) begin
            n_fail++;
            $display("FAIL reset_no_write: got %b expected all zero", o0);
        end
        rst = 1'b1;
        #1;
        n_tests++;
        if (o0 !== fetch_v() || o1 !== fetch_v()) begin
            n_fail++;
            $display("FAIL reset_to_fetch: got %b / %b expected %b", o0, o1, fetch_v());
        end
    endtask

    task automatic test_load_store();
        run("lw", LW, 3'd2, 7'h15, 1'b0, 1);
        run("sw", SW, 3'd2, 7'h3f, 1'b1, 1);
        run("lw_b2b", LW, 3'd2, 7'h00, 1'b1, 1);
    endtask

    task automatic test_alu();
        run("sub", RT, 3'd0, 7'b0100000, 1'b0, 1);
        run("add", RT, 3'd0, 7'b0000000, 1'b0, 1);
        run("addi_f7", IT, 3'd0, 7'b0100000, 1'b0, 1);
        run("sltu", RT, 3'd3, 7'b0000000, 1'b1, 1);
        run("xori", IT, 3'd4, 7'h55, 1'b0, 1);
        run("and", RT, 3'd7, 7'b0000000, 1'b0, 1);
    endtask

    task automatic test_branch();
        run("bne_z0", BR, 3'd1, 7'h00, 1'b0, 1);
        run("bne_z1", BR, 3'd1, 7'h00, 1'b1, 1);
        run("bge_z1", BR, 3'd5, 7'h00, 1'b1, 1);
        run("beq_z1", BR, 3'd0, 7'h00, 1'b1, 1);
        run("blt_z0", BR, 3'd4, 7'h00, 1'b0, 1);
        run("blt_z1", BR, 3'd4, 7'h00, 1'b1, 1);
    endtask

    task automatic test_jumps();
        run("jal", JL, 3'd3, 7'h7f, 1'b0, 1);
        run("jalr", JR, 3'd0, 7'h10, 1'b1, 1);
        run("lui", LU, 3'd5, 7'h2a, 1'b0, 1);
    endtask

    task automatic test_random();
        logic [6:0] ops[8];
        logic [2:0] rf3[6];
        logic [2:0] bf3[4];
        logic [6:0] op;
        logic [2:0] f3;
        logic [6:0] f7;
        ops = '{LW, SW, RT, IT, BR, JL, JR, LU};
        rf3 = '{3'd0, 3'd2, 3'd3, 3'd4, 3'd6, 3'd7};
        bf3 = '{3'd0, 3'd1, 3'd4, 3'd5};
        for (int k = 0; k < 60; k++) begin
            op = ops[$urandom_range(0, 7)];
            f3 = 3'($urandom);
            f7 = 7'($urandom);
            if (op == RT || op == IT) f3 = rf3[$urandom_range(0, 5)];
            if (op == RT) f7 = ($urandom_range(0, 1) == 1) ? 7'b0100000 : 7'b0000000;
            if (op == BR) f3 = bf3[$urandom_range(0, 3)];
            run("random", op, f3, f7, 1'($urandom), 1);
        end
    endtask

    task automatic test_illegal_flush();
        run("ill_opcode", 7'b1111111, 3'd0, 7'h00, 1'b0, 0);
        run("ill_shift_r", RT, 3'd1, 7'h00, 1'b0, 0);
        run("ill_shift_i", IT, 3'd5, 7'h20, 1'b0, 0);
        run("ill_branch_010", BR, 3'd2, 7'h00, 1'b1, 0);
        run("ill_branch_011", BR, 3'd3, 7'h00, 1'b0, 0);
        run("after_illegal", RT, 3'd6, 7'h00, 1'b0, 0);
    endtask

    task automatic test_halt();
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        opcode = 7'b1111111;
        func3 = 3'd0;
        func7 = 7'd0;
        #1;
        n_tests++;
        if (o1 !== fetch_v()) begin
            n_fail++;
            $display("FAIL halt_fetch: got %b expected %b", o1, fetch_v());
        end
        @(negedge clk);
        #1;
        n_tests++;
        if (o1 !== v(0, 0, 0, 0, 0, 2'b00, 2'b01, 2'b01, 3'b000, 3'b010, 0, 1)) begin
            n_fail++;
            $display("FAIL halt_decode: got %b expected illegal pulse", o1);
        end
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (k == 4) opcode = LU;
            #1;
            n_tests++;
            if (o1 !== 19'd0) begin
                n_fail++;
                $display("FAIL halt_hold cycle %0d: got %b expected all zero", k, o1);
            end
        end
        rst = 1'b0;
        #1;
        n_tests++;
        if (o1 !== 19'd0) begin
            n_fail++;
            $display("FAIL halt_reset: got %b expected all zero", o1);
        end
        @(negedge clk);
        rst = 1'b1;
        #1;
        n_tests++;
        if (o1 !== fetch_v() || o0 !== fetch_v()) begin
            n_fail++;
            $display("FAIL halt_exit: got %b / %b expected %b", o0, o1, fetch_v());
        end
        run("lui_after_halt", LU, 3'd0, 7'h00, 1'b0, 1);
    endtask

    initial begin
        test_reset();
        test_load_store();
        test_alu();
        test_branch();
        test_jumps();
        test_random();
        test_illegal_flush();
        test_halt();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/multicycle_controller.md
Name: multicycle_controller

Overview:
- Main control FSM for the multi-cycle RV32I datapath.
- Sequences one instruction over 3-5 cycles.
- Drives all datapath select and enable lines from the latched instruction fields (opcode, func3, func7) and the ALU zero flag.
- Datapath owns IR, OldPC, A, B, Data and ALUOut registers; this block owns only sequencing.

Parameters:
- ILLEGAL_HALT, 0, 1: an unsupported opcode enters HALT until reset. 0: pulse illegal_instr and return to FETCH with no writes.

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-low reset
- opcode  in  7  instruction[6:0] from IR
- func3  in  3  instruction[14:12]
- func7  in  7  instruction[31:25]
- zero  in  1  ALU zero flag
- PCWrite  out  1  PC register load enable
- AdrSrc  out  1  memory address select: 0 = PC, 1 = Result
- MemWrite  out  1  data memory write enable
- IRWrite  out  1  IR/OldPC load enable
- RegWrite  out  1  register file write enable
- ResultSrc  out  2  00 ALUOut, 01 Data, 10 ALUResult, 11 ImmExt
- ALUSrcA  out  2  00 PC, 01 OldPC, 10 A
- ALUSrcB  out  2  00 B, 01 ImmExt, 10 constant 4
- ALUControl  out  3  000 add, 001 sub, 010 and, 011 or, 100 xor, 101 slt, 110 sltu
- ImmSrc  out  3  000 I, 001 S, 010 B, 011 J, 100 U
- instr_done  out  1  one-cycle pulse in the last state of each instruction
- illegal_instr  out  1  one-cycle pulse when DECODE sees an unsupported opcode/func

Behaviour:
- Moore FSM. All outputs are combinational from state, plus opcode/func3/func7/zero where noted.
- Outputs in any state are 0 unless listed for that state.
- Reset (rst=0, async): state <= FETCH. All enables are therefore asserted as in FETCH once reset is released; during reset, force every output to 0.
- FETCH: AdrSrc=0, IRWrite=1, ALUSrcA=00, ALUSrcB=10, ALUControl=add, ResultSrc=10, PCWrite=1. Next: DECODE.
- DECODE: ALUSrcA=01, ALUSrcB=01, add, ImmSrc=J if jal else B; ALUOut latches the branch/jump target. Next state by opcode:
  - 0000011 -> MEMADR
  - 0100011 -> MEMADR
  - 0110011 -> EXEC_R
  - 0010011 -> EXEC_I
  - 1100011 -> BRANCH
  - 1101111 -> JAL
  - 1100111 -> JALR
  - 0110111 -> LUI
  - else -> illegal handling
- MEMADR: ALUSrcA=10, ALUSrcB=01, add, ImmSrc=S for sw else I. Next: MEMREAD (lw) or MEMWRITE (sw).
- MEMREAD: AdrSrc=1, ResultSrc=00 -> MEMWB.
- MEMWB: ResultSrc=01, RegWrite, instr_done -> FETCH.
- MEMWRITE: AdrSrc=1, ResultSrc=00, MemWrite, instr_done -> FETCH.
- EXEC_R: ALUSrcA=10, ALUSrcB=00, ALUControl from alu_decoder -> ALUWB.
- EXEC_I: ALUSrcA=10, ALUSrcB=01, ImmSrc=I, ALUControl from alu_decoder -> ALUWB.
- ALUWB: ResultSrc=00, RegWrite, instr_done -> FETCH.
- BRANCH: ALUSrcA=10, ALUSrcB=00, ResultSrc=00, instr_done -> FETCH.
  - beq/bne: ALUControl=sub. blt/bge: ALUControl=slt.
  - PCWrite = (beq&zero) | (bne&~zero) | (blt&~zero) | (bge&zero).
- JAL: ALUSrcA=01, ALUSrcB=10, add, ResultSrc=00, PCWrite -> ALUWB. rd = OldPC+4.
- JALR: ALUSrcA=10, ALUSrcB=01, ImmSrc=I, add, ResultSrc=10, PCWrite -> LINK.
- LINK: ALUSrcA=01, ALUSrcB=10, add -> ALUWB.
- LUI: ImmSrc=U, ResultSrc=11, RegWrite, instr_done -> FETCH.
- Latency in cycles including FETCH: lw 5, sw 4, R/I-ALU 4, branch 3, jal 4, jalr 5, lui 3.
- Supported R-type: add, sub, and, or, xor, slt, sltu.
  - Decoded by func3; func7[5]=1 with func3=000 selects sub.
- Supported I-type: addi, xori, ori, andi, slti, sltiu.
  - func7 is ignored for I-type, so addi never decodes as sub.
- Unsupported func3 (e.g. shifts, branch func3 010/011) is treated as illegal.
- Illegal handling:
  - ILLEGAL_HALT=0: illegal_instr pulses in DECODE, next state FETCH; no RegWrite/MemWrite/PCWrite beyond FETCH's.
  - ILLEGAL_HALT=1: illegal_instr pulses in DECODE, next state HALT; HALT drives all outputs 0 and holds until rst=0.
- Reset mid-instruction: state returns to FETCH immediately and outputs go 0 asynchronously. No partial write may occur after rst falls.
- Invariant: MemWrite and RegWrite are never both 1. PCWrite and IRWrite are both 1 only in FETCH.

Decomposition:
- Package ca_pkg:
  - state enum (FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXEC_R, EXEC_I, ALUWB, BRANCH, JAL, JALR, LINK, LUI, HALT)
  - opcode constants
  - ALUControl codes
  - ImmSrc codes
  - ResultSrc/ALUSrcA/ALUSrcB codes
- One sub-module alu_decoder (combinational): inputs alu_op[1:0] (00 add, 01 branch, 10 func-decoded), func3, func7[5], opcode[5]. Outputs ALUControl and an illegal flag.

Test Plan:
- Reset low mid-MEMREAD, then release -> state FETCH; first cycle after release: PCWrite=1, IRWrite=1, ALUSrcB=10.
- lw (opcode 0000011) -> states FETCH, DECODE, MEMADR, MEMREAD, MEMWB; RegWrite=1 only in cycle 5 with ResultSrc=01; instr_done high in cycle 5 only.
- sub (0110011, func3=000, func7=0100000) -> EXEC_R drives ALUControl=001; addi with imm[11:5]=0100000 -> ALUControl=000.
- bne with zero=0 -> PCWrite=1 in BRANCH; same with zero=1 -> PCWrite=0; bge with zero=1 -> ALUControl=101, PCWrite=1; each takes 3 cycles.
- jalr -> JALR asserts PCWrite with ResultSrc=10; LINK then ALUWB asserts RegWrite with ResultSrc=00; 5 cycles total.
- opcode 1111111:
  - ILLEGAL_HALT=0 -> illegal_instr pulse, back to FETCH, no RegWrite/MemWrite.
  - ILLEGAL_HALT=1 -> HALT with all outputs 0 for 10 cycles, exits only on rst=0.
